// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared sizing helpers for the bram-backed FWFT FIFO controller and its memory.
package bram_fifo_ctrl_pkg;

  // Number of bram entries addressed by an ADDR_WIDTH-bit pointer.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Occupancy counters need one extra bit so that DEPTH (and DEPTH+1 with the
  // output stage) is representable.
  function automatic int unsigned fill_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_bram.sv
// Simple dual-port block RAM: synchronous write on port A, registered read on port B.
module bram_fifo_ctrl_bram
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] doutb_q;

  always_ff @(posedge clk) begin
    if (wea) begin
      mem_q[addra] <= dina;
    end
  end

  // Output register only loads on enb, so doutb holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (enb) begin
      doutb_q <= mem_q[addrb];
    end
  end

  assign doutb = doutb_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO built on a simple dual-port bram; the bram output
// register doubles as the FIFO output stage, hiding the 1-cycle read latency.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int unsigned DEPTH      = fifo_depth(ADDR_WIDTH);
  localparam int unsigned FILL_WIDTH = fill_width(ADDR_WIDTH);
  localparam logic [FILL_WIDTH-1:0] DEPTH_CNT = FILL_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FILL_WIDTH-1:0] mem_count_q, mem_count_d;
  logic                  m_valid_q, m_valid_d;

  logic                  clear;
  logic                  wr_fire;
  logic                  rd_go;
  logic [DATA_WIDTH-1:0] doutb;

  // Handshake decode. mem_count only counts entries already committed to the
  // bram, so a word is never read in the cycle it is written.
  always_comb begin
    clear   = rst || flush;
    s_ready = !clear && (mem_count_q != DEPTH_CNT);
    wr_fire = s_valid && s_ready;
    rd_go   = !clear && (mem_count_q != '0) && (!m_valid_q || m_ready);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    m_valid_d   = m_valid_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      m_valid_d   = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_go) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end

      unique case ({wr_fire, rd_go})
        2'b10:   mem_count_d = mem_count_q + FILL_WIDTH'(1);
        2'b01:   mem_count_d = mem_count_q - FILL_WIDTH'(1);
        default: mem_count_d = mem_count_q;
      endcase

      // A fresh read refills the output stage; otherwise a taken word empties it.
      if (rd_go) begin
        m_valid_d = 1'b1;
      end else if (m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      m_valid_q   <= m_valid_d;
    end
  end

  bram_fifo_ctrl_bram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk   (clk),
    .wea   (wr_fire),
    .addra (wr_ptr_q),
    .dina  (s_data),
    .enb   (rd_go),
    .addrb (rd_ptr_q),
    .doutb (doutb)
  );

  assign m_valid    = m_valid_q;
  assign m_data     = doutb;
  assign fill_level = mem_count_q + FILL_WIDTH'(m_valid_q);

endmodule
